// File: rtl/sine_pkg.sv
// Shared widths, FSM encoding and output saturation for the sine voice path.
package sine_pkg;
  localparam int PHASE_W  = 22;
  localparam int ROM_AW   = 10;
  localparam int SAMPLE_W = 16;
  localparam int STEP_W   = 20;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  // Clamp a sign-extended sum into the 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/sine_phase_fold.sv
// Quarter-wave fold: odd quadrants mirror the address, upper half-wave negates.
module sine_phase_fold
  import sine_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               negate
);
  logic [ROM_AW-1:0] raw;

  assign raw      = phase[19:10];
  assign rom_addr = phase[20] ? ~raw : raw;
  assign negate   = phase[21];
endmodule

// File: rtl/sine_voice_scheduler.sv
// Shares one synchronous sine ROM across NUM_VOICES phase accumulators and
// mixes the voices into one scaled, saturated sample per generate_next.
module sine_voice_scheduler
  import sine_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int MIX_SHIFT  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         generate_next,
  input  logic [STEP_W*NUM_VOICES-1:0] step_size,
  input  logic [NUM_VOICES-1:0]        voice_en,
  output logic [ROM_AW-1:0]            rom_addr,
  input  logic [SAMPLE_W-1:0]          rom_dout,
  output logic [SAMPLE_W-1:0]          sample,
  output logic                         sample_ready,
  output logic                         busy,
  output logic                         overrun
);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_t                                state, state_nxt;
  logic [IDX_W-1:0]                      idx;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]    phase;
  logic [NUM_VOICES-1:0][STEP_W-1:0]     steps;
  logic signed [ACC_W-1:0]               acc, term, dout_ext, shifted;
  logic [ROM_AW-1:0]                     addr_q, fold_addr;
  logic                                  fold_neg, neg_q, en_q, last;

  assign steps    = step_size;
  assign last     = (idx == IDX_W'(NUM_VOICES - 1));
  assign dout_ext = ACC_W'($signed(rom_dout));
  assign shifted  = acc >>> MIX_SHIFT;

  sine_phase_fold u_fold (
    .phase    (phase[idx]),
    .rom_addr (fold_addr),
    .negate   (fold_neg)
  );

  // Address is live during ISSUE so the ROM's registered output lands in CAPTURE.
  assign rom_addr     = (state == ISSUE) ? fold_addr : addr_q;
  assign sample_ready = (state == DONE);

  always_comb begin
    term = '0;
    if (en_q) term = neg_q ? -dout_ext : dout_ext;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (generate_next) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = last ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      addr_q  <= '0;
      neg_q   <= 1'b0;
      en_q    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      sample  <= '0;
      phase   <= '0;
    end else begin
      state <= state_nxt;
      if (generate_next && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (generate_next) begin
          acc  <= '0;
          idx  <= '0;
          busy <= 1'b1;
        end
        ISSUE: begin
          addr_q <= fold_addr;
          neg_q  <= fold_neg;
          en_q   <= voice_en[idx];
          // Disabled voices park at phase 0 so a re-enabled note starts cleanly.
          for (int v = 0; v < NUM_VOICES; v++)
            if (idx == IDX_W'(v))
              phase[v] <= voice_en[v] ? phase[v] + PHASE_W'(steps[v]) : '0;
        end
        CAPTURE: begin
          acc <= acc + term;
          if (!last) idx <= idx + 1'b1;
        end
        DONE: begin
          sample <= sat16(32'(shifted));
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench: dut_a mixes with shift 2 over an address-echo ROM,
// dut_b mixes with shift 0 over a ROM pinned at full scale.
module tb_sine_voice_scheduler;
  logic        clk, reset, gen_a, gen_b;
  logic [59:0] step_size;
  logic [2:0]  voice_en;
  logic [9:0]  rom_addr_a, rom_addr_b;
  logic [15:0] rom_dout_a, sample_a, sample_b;
  logic        rdy_a, rdy_b, busy_a, busy_b, ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  sine_voice_scheduler #(.NUM_VOICES(3), .MIX_SHIFT(2)) dut_a (
    .clk(clk), .reset(reset), .generate_next(gen_a), .step_size(step_size),
    .voice_en(voice_en), .rom_addr(rom_addr_a), .rom_dout(rom_dout_a),
    .sample(sample_a), .sample_ready(rdy_a), .busy(busy_a), .overrun(ovr_a));

  sine_voice_scheduler #(.NUM_VOICES(3), .MIX_SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .generate_next(gen_b), .step_size(step_size),
    .voice_en(voice_en), .rom_addr(rom_addr_b), .rom_dout(16'h7FFF),
    .sample(sample_b), .sample_ready(rdy_b), .busy(busy_b), .overrun(ovr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_dout_a <= {6'b0, rom_addr_a};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sample is registered on the DONE edge, so read it just after that edge.
  always begin
    @(negedge clk);
    if (rdy_a) begin
      @(posedge clk); #1;
      if (qa.size() == 0) chk("unexpected_ready_a", 1, 0);
      else chk("sample_a", sample_a, qa.pop_front());
    end
  end

  always begin
    @(negedge clk);
    if (rdy_b) begin
      @(posedge clk); #1;
      if (qb.size() == 0) chk("unexpected_ready_b", 1, 0);
      else chk("sample_b", sample_b, qb.pop_front());
    end
  end

  // One request; dup>0 re-pulses generate_next on dut_a in that cycle of the sequence.
  task automatic gen(input bit d, input logic [59:0] st, input logic [2:0] en,
                     input logic [9:0] ea, input logic [15:0] es, input int dup);
    int lat = 1;
    bit seen = 0;
    step_size = st;
    voice_en  = en;
    if (d) begin qb.push_back(es); gen_b = 1'b1; end
    else   begin qa.push_back(es); gen_a = 1'b1; end
    @(negedge clk);
    gen_a = 1'b0; gen_b = 1'b0;
    chk("rom_addr_voice0", d ? rom_addr_b : rom_addr_a, ea);
    chk("busy_set", d ? busy_b : busy_a, 1);
    while (!seen && lat < 20) begin
      if (d ? rdy_b : rdy_a) seen = 1;
      else begin
        if (lat == dup) gen_a = 1'b1;
        @(negedge clk);
        gen_a = 1'b0;
        lat++;
      end
    end
    chk("latency", seen ? lat : 99, 7);
    @(negedge clk);
    chk("busy_clear", d ? busy_b : busy_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset = 1'b1; gen_a = 1'b0; gen_b = 1'b0; step_size = '0; voice_en = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sample", sample_a, 0);
    chk("rst_ready", rdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_rom_addr", rom_addr_a, 0);

    // Voice 0 walk through all quadrants and the 22-bit wrap.
    gen(0, {40'h0, 20'h00400}, 3'b001, 10'h000, 16'h0000, 0);  // ph 0
    gen(0, {40'h0, 20'hFFC00}, 3'b001, 10'h001, 16'h0000, 0);  // ph 0x000400
    gen(0, {40'h0, 20'hFFC00}, 3'b001, 10'h3FF, 16'h00FF, 0);  // ph 0x100000
    gen(0, {40'h0, 20'h00800}, 3'b001, 10'h000, 16'h0000, 0);  // ph 0x1FFC00
    gen(0, {40'h0, 20'hFFC00}, 3'b001, 10'h001, 16'hFFFF, 0);  // ph 0x200400
    gen(0, {40'h0, 20'hFFC00}, 3'b001, 10'h3FF, 16'hFF00, 0);  // ph 0x300000
    gen(0, {40'h0, 20'h00800}, 3'b001, 10'h000, 16'h0000, 0);  // ph 0x3FFC00
    gen(0, {40'h0, 20'h7FC00}, 3'b001, 10'h001, 16'h0000, 0);  // ph 0x000400 after wrap
    chk("overrun_clear", ovr_a, 0);
    gen(0, {40'h0, 20'h00000}, 3'b001, 10'h200, 16'h0080, 3);  // ph 0x080000, re-request mid-run
    chk("overrun_set", ovr_a, 1);

    // Saturating mix, all voices stepping a half-quadrant per sample.
    gen(1, {3{20'h80000}}, 3'b111, 10'h000, 16'h7FFF, 0);
    gen(1, {3{20'h80000}}, 3'b111, 10'h200, 16'h7FFF, 0);
    gen(1, {3{20'h80000}}, 3'b111, 10'h3FF, 16'h7FFF, 0);
    gen(1, {3{20'h80000}}, 3'b111, 10'h1FF, 16'h7FFF, 0);
    gen(1, {3{20'h80000}}, 3'b111, 10'h000, 16'h8000, 0);
    gen(1, {3{20'h80000}}, 3'b001, 10'h200, 16'h8001, 0);      // lone voice, -32767
    gen(1, {3{20'h80000}}, 3'b111, 10'h3FF, 16'h7FFF, 0);      // voices 1,2 restart at 0

    // Reset while the first voice is in CAPTURE.
    step_size = '0; voice_en = 3'b001; gen_a = 1'b1;
    @(negedge clk); gen_a = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_sample", sample_a, 0);
    chk("midrst_sample_b", sample_b, 0);
    chk("midrst_overrun", ovr_a, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rdy_a) cnt++;
    end
    chk("midrst_no_ready", cnt, 0);
    gen(0, {40'h0, 20'h00400}, 3'b001, 10'h000, 16'h0000, 0);  // phase back at 0

    repeat (3) @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
